// File: rtl/ticket_counter_bank_if.sv
// ticket_counter_bank_if: request/response bundle for the ticket counter bank.
//   master : requester side (drives req_valid/req_ch/req_auto and rsp_ready)
//   slave  : bank side (drives req_ready and rsp_valid/rsp_ch/rsp_cnt/rsp_wrap)
//   req_*  : valid/ready request port carrying the channel and static/automatic mode
//   rsp_*  : one-entry held response carrying channel, count and wrap flag
interface ticket_counter_bank_if #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned CW = $clog2(NCH);

   logic             req_valid;
   logic             req_ready;
   logic [CW-1:0]    req_ch;
   logic             req_auto;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [CW-1:0]    rsp_ch;
   logic [WIDTH-1:0] rsp_cnt;
   logic             rsp_wrap;

   modport master (
      output req_valid, req_ch, req_auto, rsp_ready,
      input  req_ready, rsp_valid, rsp_ch, rsp_cnt, rsp_wrap
   );

   modport slave (
      input  req_valid, req_ch, req_auto, rsp_ready,
      output req_ready, rsp_valid, rsp_ch, rsp_cnt, rsp_wrap
   );
endinterface

// File: rtl/ticket_counter_bank.sv
// ticket_counter_bank: NCH persistent WIDTH-bit call counters behind a
// valid/ready request port with a one-entry registered response.
//   static request    : bump the channel count, return the new value
//   automatic request : return INIT+1, leave the stored count alone
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   clr   : per-channel synchronous clear to INIT
//   bus   : ticket_counter_bank_if.slave (req_* in, req_ready/rsp_* out)
// Build option: define TICKET_SAT_EN to saturate static increments at
// all-ones instead of wrapping to zero.
module ticket_counter_bank #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned INIT  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       clr,
   ticket_counter_bank_if.slave bus
);
   localparam int unsigned CW = $clog2(NCH);

   typedef logic [WIDTH-1:0] cnt_t;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam cnt_t INIT_V  = WIDTH'(INIT);
   localparam cnt_t FRESH_V = WIDTH'(INIT + 1);

   state_t        state_q, state_d;
   cnt_t          cnt_q [NCH];
   cnt_t          cnt_d [NCH];
   logic [CW-1:0] rsp_ch_q, rsp_ch_d;
   cnt_t          rsp_cnt_q, rsp_cnt_d;
   logic          rsp_wrap_q, rsp_wrap_d;

   logic          accept;
   logic          ch_ok;
   cnt_t          cur;
   cnt_t          inc;
   logic          all_ones;

   // Channel index range check; only reachable when NCH is not a power of two.
   generate
      if (NCH == 2**CW) begin : g_pow2
         assign ch_ok = 1'b1;
      end else begin : g_npow2
         assign ch_ok = (32'(bus.req_ch) < NCH);
      end
   endgenerate

   assign bus.req_ready = (state_q == EMPTY) || bus.rsp_ready;
   assign accept        = bus.req_valid && bus.req_ready;

   // Count seen by a static call: a same-cycle clear takes effect first.
   always_comb begin
      cur = INIT_V;
      if (ch_ok && !clr[bus.req_ch]) begin
         cur = cnt_q[bus.req_ch];
      end
      all_ones = (cur == '1);
`ifdef TICKET_SAT_EN
      inc = all_ones ? cur : cur + WIDTH'(1);
`else
      inc = cur + WIDTH'(1);
`endif
   end

   // Next-state: response slot occupancy, response payload, counter updates.
   always_comb begin
      state_d    = state_q;
      rsp_ch_d   = rsp_ch_q;
      rsp_cnt_d  = rsp_cnt_q;
      rsp_wrap_d = rsp_wrap_q;

      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = clr[i] ? INIT_V : cnt_q[i];
         if (accept && ch_ok && !bus.req_auto && (bus.req_ch == CW'(i))) begin
            cnt_d[i] = inc;
         end
      end

      if (state_q == FULL && bus.rsp_ready) begin
         state_d = EMPTY;
      end

      if (accept) begin
         state_d  = FULL;
         rsp_ch_d = bus.req_ch;
         if (!ch_ok) begin
            rsp_cnt_d  = '0;
            rsp_wrap_d = 1'b0;
         end else if (bus.req_auto) begin
            rsp_cnt_d  = FRESH_V;
            rsp_wrap_d = 1'b0;
         end else begin
            rsp_cnt_d  = inc;
            rsp_wrap_d = all_ones;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         rsp_ch_q   <= '0;
         rsp_cnt_q  <= '0;
         rsp_wrap_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= INIT_V;
         end
      end else begin
         state_q    <= state_d;
         rsp_ch_q   <= rsp_ch_d;
         rsp_cnt_q  <= rsp_cnt_d;
         rsp_wrap_q <= rsp_wrap_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.rsp_valid = (state_q == FULL);
   assign bus.rsp_ch    = rsp_ch_q;
   assign bus.rsp_cnt   = rsp_cnt_q;
   assign bus.rsp_wrap  = rsp_wrap_q;

endmodule
